// File: rtl/axi_pkg.sv
// Shared AXI4 types, protocol constants and payload-width helpers
// for the register slice.
package axi_pkg;

  typedef enum logic {
    SLICE_BYPASS = 1'b0,
    SLICE_FULL   = 1'b1
  } slice_mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // len 8 + size 3 + burst 2 + lock 1 + cache 4 + prot 3 + qos 4 + region 4
  function automatic int aw_w(input int id_w, input int addr_w);
    return id_w + addr_w + 29;
  endfunction

  function automatic int w_w(input int data_w);
    return data_w + data_w / 8 + 1;
  endfunction

  function automatic int b_w(input int id_w);
    return id_w + 2;
  endfunction

  function automatic int r_w(input int id_w, input int data_w);
    return id_w + data_w + 3;
  endfunction

endpackage

// File: rtl/axi_if.sv
// Parametrised AXI4 bundle with master and slave views.
interface axi_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic [3:0]          awregion;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic [3:0]          arregion;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst,
    output awlock, awcache, awprot, awqos, awregion,
    output awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst,
    output arlock, arcache, arprot, arqos, arregion,
    output arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst,
    input  awlock, awcache, awprot, awqos, awregion,
    input  awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst,
    input  arlock, arcache, arprot, arqos, arregion,
    input  arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_skid_buffer.sv
// One valid/ready channel stage: plain wires, or a two-entry skid
// buffer with registered ready, valid and payload.
module axi_skid_buffer
  import axi_pkg::*;
#(
  parameter int          WIDTH = 8,
  parameter slice_mode_e MODE  = SLICE_FULL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  if (MODE != SLICE_BYPASS && MODE != SLICE_FULL) begin : g_bad_mode
    $error("axi_skid_buffer: illegal MODE");
  end

  if (MODE == SLICE_BYPASS) begin : g_bypass

    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign in_ready  = out_ready;

  end else begin : g_full

    skid_state_e      state_q, state_d;
    logic             rdy_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_hs, out_hs;
    logic             ld_out, ld_skid, sel_skid;

    assign in_hs     = in_valid & rdy_q;
    assign out_hs    = out_valid & out_ready;
    assign in_ready  = rdy_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = out_q;

    always_comb begin
      state_d  = state_q;
      ld_out   = 1'b0;
      ld_skid  = 1'b0;
      sel_skid = 1'b0;
      unique case (state_q)
        ST_EMPTY: begin
          if (in_hs) begin
            state_d = ST_ONE;
            ld_out  = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_hs && !out_hs) begin
            state_d = ST_FULL;
            ld_skid = 1'b1;
          end else if (!in_hs && out_hs) begin
            state_d = ST_EMPTY;
          end else if (in_hs && out_hs) begin
            ld_out = 1'b1;
          end
        end
        ST_FULL: begin
          // rdy_q is low here, so only the drain side can move
          if (out_hs) begin
            state_d  = ST_ONE;
            ld_out   = 1'b1;
            sel_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_EMPTY;
        rdy_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        rdy_q   <= (state_d != ST_FULL);
      end
    end

    always_ff @(posedge clk) begin
      if (ld_out) out_q <= sel_skid ? skid_q : in_data;
      if (ld_skid) skid_q <= in_data;
    end

  end

endmodule

// File: rtl/axi_register_slice.sv
// AXI4 register slice: five independent channel stages, the top
// only packs and unpacks the channel payloads.
module axi_register_slice
  import axi_pkg::*;
#(
  parameter int          ID_W    = 4,
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter slice_mode_e AW_MODE = SLICE_FULL,
  parameter slice_mode_e W_MODE  = SLICE_FULL,
  parameter slice_mode_e B_MODE  = SLICE_FULL,
  parameter slice_mode_e AR_MODE = SLICE_FULL,
  parameter slice_mode_e R_MODE  = SLICE_FULL
) (
  input  logic   clk,
  input  logic   rst,
  axi_if.slave   s,
  axi_if.master  m
);

  if (DATA_W < 8 || DATA_W > 1024 || (DATA_W % 8) != 0) begin : g_bad_dw
    $error("axi_register_slice: illegal DATA_W");
  end

  localparam int AWW = aw_w(ID_W, ADDR_W);
  localparam int WW  = w_w(DATA_W);
  localparam int BW  = b_w(ID_W);
  localparam int RW  = r_w(ID_W, DATA_W);

  logic [AWW-1:0] aw_in, aw_out;
  logic [WW-1:0]  w_in,  w_out;
  logic [BW-1:0]  b_in,  b_out;
  logic [AWW-1:0] ar_in, ar_out;
  logic [RW-1:0]  r_in,  r_out;

  assign aw_in = {s.awid, s.awaddr, s.awlen, s.awsize,
                  s.awburst, s.awlock, s.awcache, s.awprot,
                  s.awqos, s.awregion};
  assign {m.awid, m.awaddr, m.awlen, m.awsize,
          m.awburst, m.awlock, m.awcache, m.awprot,
          m.awqos, m.awregion} = aw_out;

  assign w_in = {s.wdata, s.wstrb, s.wlast};
  assign {m.wdata, m.wstrb, m.wlast} = w_out;

  assign b_in = {m.bid, m.bresp};
  assign {s.bid, s.bresp} = b_out;

  assign ar_in = {s.arid, s.araddr, s.arlen, s.arsize,
                  s.arburst, s.arlock, s.arcache, s.arprot,
                  s.arqos, s.arregion};
  assign {m.arid, m.araddr, m.arlen, m.arsize,
          m.arburst, m.arlock, m.arcache, m.arprot,
          m.arqos, m.arregion} = ar_out;

  assign r_in = {m.rid, m.rdata, m.rresp, m.rlast};
  assign {s.rid, s.rdata, s.rresp, s.rlast} = r_out;

  axi_skid_buffer #(.WIDTH(AWW), .MODE(AW_MODE)) u_aw (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s.awvalid),
    .in_ready  (s.awready),
    .in_data   (aw_in),
    .out_valid (m.awvalid),
    .out_ready (m.awready),
    .out_data  (aw_out)
  );

  axi_skid_buffer #(.WIDTH(WW), .MODE(W_MODE)) u_w (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s.wvalid),
    .in_ready  (s.wready),
    .in_data   (w_in),
    .out_valid (m.wvalid),
    .out_ready (m.wready),
    .out_data  (w_out)
  );

  // Response channels run from the downstream slave back upstream
  axi_skid_buffer #(.WIDTH(BW), .MODE(B_MODE)) u_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (m.bvalid),
    .in_ready  (m.bready),
    .in_data   (b_in),
    .out_valid (s.bvalid),
    .out_ready (s.bready),
    .out_data  (b_out)
  );

  axi_skid_buffer #(.WIDTH(AWW), .MODE(AR_MODE)) u_ar (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s.arvalid),
    .in_ready  (s.arready),
    .in_data   (ar_in),
    .out_valid (m.arvalid),
    .out_ready (m.arready),
    .out_data  (ar_out)
  );

  axi_skid_buffer #(.WIDTH(RW), .MODE(R_MODE)) u_r (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (m.rvalid),
    .in_ready  (m.rready),
    .in_data   (r_in),
    .out_valid (s.rvalid),
    .out_ready (s.rready),
    .out_data  (r_out)
  );

endmodule

// File: tb/tb_axi_register_slice.sv
// Scoreboard bench for axi_register_slice: a 64-bit all-FULL slice
// and a 128-bit slice with a bypassed B channel.
module tb_axi_register_slice;
  import axi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  axi_if #(.ID_W(4), .ADDR_W(32), .DATA_W(64))  sw ();
  axi_if #(.ID_W(4), .ADDR_W(32), .DATA_W(64))  mw ();
  axi_if #(.ID_W(6), .ADDR_W(32), .DATA_W(128)) sr ();
  axi_if #(.ID_W(6), .ADDR_W(32), .DATA_W(128)) mr ();

  axi_register_slice #(
    .ID_W(4), .ADDR_W(32), .DATA_W(64)
  ) dut_w (
    .clk(clk), .rst(rst), .s(sw), .m(mw)
  );

  axi_register_slice #(
    .ID_W(6), .ADDR_W(32), .DATA_W(128), .B_MODE(SLICE_BYPASS)
  ) dut_r (
    .clk(clk), .rst(rst), .s(sr), .m(mr)
  );

  logic [255:0] aw_q[$];
  logic [255:0] w_q[$];
  logic [255:0] r_q[$];

  int aw_hs0 = -1, aw_first_v = -1;
  int aw_m_first = -1, aw_m_last = -1, aw_m_cnt = 0;
  int ar_m_cnt = 0;
  int r_cnt = 0, r_t0 = -1, r_t1 = -1;
  logic w_stall_prev = 1'b0;
  logic [63:0] w_prev = '0;
  logic r_rand_done = 1'b0;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting on DUT", nm);
  endtask

  task automatic init_bus();
    sw.awid = '0; sw.awaddr = '0; sw.awlen = '0; sw.awsize = 3'd2;
    sw.awburst = INCR; sw.awlock = 1'b0; sw.awcache = '0;
    sw.awprot = '0; sw.awqos = '0; sw.awregion = '0; sw.awvalid = 1'b0;
    sw.wdata = '0; sw.wstrb = '0; sw.wlast = 1'b0; sw.wvalid = 1'b0;
    sw.bready = 1'b0;
    sw.arid = '0; sw.araddr = '0; sw.arlen = '0; sw.arsize = 3'd2;
    sw.arburst = INCR; sw.arlock = 1'b0; sw.arcache = '0;
    sw.arprot = '0; sw.arqos = '0; sw.arregion = '0; sw.arvalid = 1'b0;
    sw.rready = 1'b0;
    mw.awready = 1'b0; mw.wready = 1'b0; mw.arready = 1'b0;
    mw.bid = '0; mw.bresp = '0; mw.bvalid = 1'b0;
    mw.rid = '0; mw.rdata = '0; mw.rresp = '0; mw.rlast = 1'b0;
    mw.rvalid = 1'b0;
    sr.awid = '0; sr.awaddr = '0; sr.awlen = '0; sr.awsize = '0;
    sr.awburst = '0; sr.awlock = 1'b0; sr.awcache = '0;
    sr.awprot = '0; sr.awqos = '0; sr.awregion = '0; sr.awvalid = 1'b0;
    sr.wdata = '0; sr.wstrb = '0; sr.wlast = 1'b0; sr.wvalid = 1'b0;
    sr.bready = 1'b0;
    sr.arid = '0; sr.araddr = '0; sr.arlen = '0; sr.arsize = '0;
    sr.arburst = '0; sr.arlock = 1'b0; sr.arcache = '0;
    sr.arprot = '0; sr.arqos = '0; sr.arregion = '0; sr.arvalid = 1'b0;
    sr.rready = 1'b0;
    mr.awready = 1'b0; mr.wready = 1'b0; mr.arready = 1'b0;
    mr.bid = '0; mr.bresp = '0; mr.bvalid = 1'b0;
    mr.rid = '0; mr.rdata = '0; mr.rresp = '0; mr.rlast = 1'b0;
    mr.rvalid = 1'b0;
  endtask

  // Source drivers: present a beat, hold it until accepted
  task automatic aw_beat(input int k);
    sw.awvalid = 1'b1;
    sw.awid = 4'(k);
    sw.awaddr = 32'h100 + 32'(4 * k);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (sw.awready) begin
        aw_q.push_back({4'(k), 32'h100 + 32'(4 * k), 8'd0, INCR});
        if (k == 0) aw_hs0 = cyc;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    tmo("aw_accept");
  endtask

  task automatic w_beat(input int k);
    sw.wvalid = 1'b1;
    sw.wdata = 64'hA5A5_0000_0000_0000 | 64'(k);
    sw.wstrb = 8'hFF;
    sw.wlast = (k == 3);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (sw.wready) begin
        w_q.push_back({64'hA5A5_0000_0000_0000 | 64'(k), 8'hFF, k == 3});
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    tmo("w_accept");
  endtask

  task automatic ar_beat(input int k);
    sw.arvalid = 1'b1;
    sw.arid = 4'(k);
    sw.araddr = 32'h200 + 32'(4 * k);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (sw.arready) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    tmo("ar_accept");
  endtask

  task automatic r_beat(input int k, input int idle);
    logic [127:0] d;
    d = {32'(32'hC0DE_0000 + k), 32'(k * 3),
         32'(32'hFFFF_0000 ^ k), 32'(k)};
    mr.rvalid = 1'b0;
    repeat (idle) begin @(posedge clk); #1; end
    mr.rvalid = 1'b1;
    mr.rid = 6'(k);
    mr.rdata = d;
    mr.rresp = 2'(k);
    mr.rlast = ((k % 4) == 3);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (mr.rready) begin
        r_q.push_back({6'(k), d, 2'(k), (k % 4) == 3});
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    tmo("r_accept");
  endtask

  // Sink-side monitors
  always @(negedge clk) begin
    if (mw.awvalid && aw_first_v < 0) aw_first_v = cyc;
    if (mw.awvalid && mw.awready) begin
      if (aw_m_first < 0) aw_m_first = cyc;
      aw_m_last = cyc;
      aw_m_cnt++;
      if (aw_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL aw_extra: unexpected beat id %0h", mw.awid);
      end else begin
        chk("aw_beat", {mw.awid, mw.awaddr, mw.awlen, mw.awburst},
            aw_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (w_stall_prev) chk("w_stable", mw.wdata, w_prev);
    w_stall_prev = mw.wvalid && !mw.wready;
    w_prev = mw.wdata;
    if (mw.wvalid && mw.wready) begin
      if (w_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL w_extra: unexpected beat %0h", mw.wdata);
      end else begin
        chk("w_beat", {mw.wdata, mw.wstrb, mw.wlast}, w_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (mw.arvalid && mw.arready) ar_m_cnt++;
  end

  always @(negedge clk) begin
    if (sr.rvalid && sr.rready) begin
      if (r_cnt == 100) r_t0 = cyc;
      if (r_cnt == 115) r_t1 = cyc;
      r_cnt++;
      if (r_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL r_extra: unexpected beat id %0h", sr.rid);
      end else begin
        chk("r_beat", {sr.rid, sr.rdata, sr.rresp, sr.rlast},
            r_q.pop_front());
      end
    end
  end

  initial begin
    init_bus();

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy_w", {sw.awready, sw.wready, sw.arready,
                      mw.bready, mw.rready}, 5'b00000);
    chk("rst_rdy_r", {sr.awready, sr.wready, sr.arready, mr.rready},
        4'b0000);
    chk("rst_vld", {mw.awvalid, mw.wvalid, mw.arvalid, sw.bvalid,
                    sw.rvalid, sr.rvalid}, 6'b000000);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rel_rdy_w", {sw.awready, sw.wready, sw.arready,
                      mw.bready, mw.rready}, 5'b11111);
    chk("rel_rdy_r", {sr.awready, sr.wready, sr.arready, mr.rready},
        4'b1111);
    @(posedge clk); #1;

    // AW streaming with the sink always ready
    mw.awready = 1'b1;
    for (int k = 0; k < 8; k++) aw_beat(k);
    sw.awvalid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("aw_latency", 32'(aw_first_v - aw_hs0), 32'd1);
    chk("aw_count", 32'(aw_m_cnt), 32'd8);
    chk("aw_span", 32'(aw_m_last - aw_m_first), 32'd7);

    // W with sink backpressure in cycles 2..5
    fork
      begin
        for (int k = 0; k < 4; k++) w_beat(k);
        sw.wvalid = 1'b0;
      end
      begin
        mw.wready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        mw.wready = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        mw.wready = 1'b1;
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("w_full_rdy", sw.wready, 1'b0);
        chk("w_stall_vld", mw.wvalid, 1'b1);
      end
    join
    for (int t = 0; t < 50 && w_q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    if (w_q.size() != 0) tmo("w_drain");

    // B bypass: same-cycle pass-through both ways
    mr.bvalid = 1'b1;
    mr.bid = 6'd3;
    mr.bresp = SLVERR;
    sr.bready = 1'b0;
    #1;
    chk("b_vld", sr.bvalid, 1'b1);
    chk("b_id", sr.bid, 6'd3);
    chk("b_resp", sr.bresp, 2'b10);
    chk("b_rdy0", mr.bready, 1'b0);
    sr.bready = 1'b1;
    #1;
    chk("b_rdy1", mr.bready, 1'b1);
    mr.bvalid = 1'b0;
    #1;
    chk("b_vld0", sr.bvalid, 1'b0);
    @(posedge clk); #1;

    // R: random source gaps and random sink ready
    fork
      begin
        for (int k = 0; k < 100; k++) r_beat(k, int'($urandom_range(0, 2)));
        mr.rvalid = 1'b0;
        r_rand_done = 1'b1;
      end
      begin
        while (!r_rand_done) begin
          @(posedge clk); #1;
          sr.rready = 1'($urandom_range(0, 1));
        end
      end
    join
    sr.rready = 1'b1;
    for (int k = 100; k < 116; k++) r_beat(k, 0);
    mr.rvalid = 1'b0;
    for (int t = 0; t < 50 && r_q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    if (r_q.size() != 0) tmo("r_drain");
    chk("r_count", 32'(r_cnt), 32'd116);
    chk("r_tput", 32'(r_t1 - r_t0), 32'd15);

    // AR: reset while two beats are held
    mw.arready = 1'b0;
    ar_beat(1);
    ar_beat(2);
    sw.arvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("ar_full_rdy", sw.arready, 1'b0);
    chk("ar_held", {mw.arvalid, mw.arid}, {1'b1, 4'd1});
    @(posedge clk); #1;
    rst = 1'b0;
    mw.arready = 1'b1;
    @(negedge clk);
    chk("ar_rst_vld", mw.arvalid, 1'b0);
    chk("ar_rst_rdy", sw.arready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("ar_rel_rdy", sw.arready, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("ar_no_emit", 32'(ar_m_cnt), 32'd0);
    chk("ar_vld_low", mw.arvalid, 1'b0);

    chk("aw_q_empty", 32'(aw_q.size()), 32'd0);
    chk("w_q_empty", 32'(w_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
